lvds_bitslip_aligner: RTL and testbench

//  Multi-channel word aligner that sits after a bank of NUM_CH ISERDESE2 deserializers, in the clkdiv domain.
//  Per channel, it compares each deserialized word against a training pattern.
//  On mismatch it issues single-cycle bitslip pulses and waits for them to settle.
//  It declares lock after MATCH_COUNT consecutive matches and flags failure after a full rotation with no match.
//  It also applies optional bit-order reversal and registers the parallel data for downstream logic.

---
 rtl/lvds_bitslip_aligner.sv | 133 +++++++++++++
 tb/tb_lvds_bitslip_aligner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_bitslip_aligner.sv
// lvds_bitslip_aligner: per-lane word alignment after an ISERDES bank using bitslip pulses,
// with lock/loss tracking, alignment-failure flagging and optional bit reversal.
module lvds_bitslip_aligner #(
    parameter int NUM_CH = 4,
    parameter int DATA_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3E0,
    parameter bit BIT_REVERSE = 1'b1,
    parameter int SETTLE_CYCLES = 4,
    parameter int MATCH_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    localparam int SW = $clog2(DATA_WIDTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         train_en,
    input  logic                         retrain,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            bitslip,
    output logic [NUM_CH-1:0]            locked,
    output logic [NUM_CH-1:0]            align_err,
    output logic                         all_locked,
    output logic [NUM_CH*SW-1:0]         slip_cnt
);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, COMPARE, SLIP, SETTLE, LOCKED, FAIL} state_t;

    logic [NUM_CH*DATA_WIDTH-1:0] data_fmt;

    always_comb begin
        data_fmt = '0;
        for (int l = 0; l < NUM_CH; l++)
            for (int b = 0; b < DATA_WIDTH; b++)
                data_fmt[l*DATA_WIDTH+b] = BIT_REVERSE ? data_in[l*DATA_WIDTH+DATA_WIDTH-1-b]
                                                       : data_in[l*DATA_WIDTH+b];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) data_out <= '0;
        else       data_out <= data_fmt;

    assign all_locked = &locked;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        state_t          state;
        logic [SW-1:0]   slips;
        logic [MW-1:0]   match_cnt;
        logic [LW-1:0]   loss_cnt;
        logic [TW-1:0]   settle;
        logic            slip_q, lock_q, err_q;
        logic            hit;

        // Comparisons always look at the registered word, one cycle behind data_in.
        assign hit = data_out[g*DATA_WIDTH +: DATA_WIDTH] == TRAIN_PATTERN;
        assign slip_cnt[g*SW +: SW] = slips;
        assign bitslip[g] = slip_q;
        assign locked[g] = lock_q;
        assign align_err[g] = err_q;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                state     <= IDLE;
                slips     <= '0;
                match_cnt <= '0;
                loss_cnt  <= '0;
                settle    <= '0;
                slip_q    <= 1'b0;
                lock_q    <= 1'b0;
                err_q     <= 1'b0;
            end else if (retrain) begin
                state  <= IDLE;
                slip_q <= 1'b0;
                lock_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                slip_q <= 1'b0;
                case (state)
                    IDLE: if (train_en) begin
                        slips     <= '0;
                        match_cnt <= '0;
                        state     <= COMPARE;
                    end
                    COMPARE: if (!train_en) state <= IDLE;
                    else if (hit) begin
                        match_cnt <= match_cnt + MW'(1);
                        if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                            state    <= LOCKED;
                            lock_q   <= 1'b1;
                            loss_cnt <= '0;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (slips == SW'(DATA_WIDTH)) begin
                            state <= FAIL;
                            err_q <= 1'b1;
                        end else begin
                            state  <= SLIP;
                            slip_q <= 1'b1;
                            slips  <= slips + SW'(1);
                        end
                    end
                    SLIP: begin
                        settle <= TW'(SETTLE_CYCLES - 1);
                        state  <= train_en ? SETTLE : IDLE;
                    end
                    SETTLE: if (!train_en) state <= IDLE;
                    else if (settle == '0) begin
                        state     <= COMPARE;
                        match_cnt <= '0;
                    end else settle <= settle - TW'(1);
                    // Monitoring only while training data is present; otherwise lock is held.
                    LOCKED: if (train_en) begin
                        if (hit) loss_cnt <= '0;
                        else if (loss_cnt == LW'(LOSS_COUNT - 1)) begin
                            state     <= COMPARE;
                            lock_q    <= 1'b0;
                            slips     <= '0;
                            match_cnt <= '0;
                            loss_cnt  <= '0;
                        end else loss_cnt <= loss_cnt + LW'(1);
                    end
                    FAIL: if (!train_en) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
    end
endmodule

// File: tb/tb_lvds_bitslip_aligner.sv
// tb_lvds_bitslip_aligner: randomized lane offsets through an ISERDES bitslip model,
// per-cycle rule checks plus scenario-level timing and count expectations.
module tb_lvds_bitslip_aligner;
    localparam int NC = 4, DW = 10, SW = $clog2(DW + 1), SET = 4, MC = 16, LC = 4;
    localparam logic [DW-1:0] TP = 10'h3E0;

    logic clk = 1'b0, reset = 1'b1, train_en = 1'b0, retrain = 1'b0;
    logic [NC*DW-1:0] data_in = '0, data_out;
    logic [NC-1:0] bitslip, locked, align_err;
    logic all_locked;
    logic [NC*SW-1:0] slip_cnt;

    int checks = 0, errors = 0;

    lvds_bitslip_aligner #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .TRAIN_PATTERN(TP), .BIT_REVERSE(1'b1),
        .SETTLE_CYCLES(SET), .MATCH_COUNT(MC), .LOSS_COUNT(LC)
    ) dut (
        .clk(clk), .reset(reset), .train_en(train_en), .retrain(retrain),
        .data_in(data_in), .data_out(data_out), .bitslip(bitslip), .locked(locked),
        .align_err(align_err), .all_locked(all_locked), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) w = {w[DW-2:0], w[DW-1]};
        return w;
    endfunction

    function automatic logic [NC*DW-1:0] rev_bus(input logic [NC*DW-1:0] b);
        logic [NC*DW-1:0] r;
        for (int l = 0; l < NC; l++) r[l*DW +: DW] = rev(b[l*DW +: DW]);
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Lane source model: 0 = training word rotated by phase, 1 = constant, 2 = random
    int mode[NC], phase[NC];
    logic [DW-1:0] cval[NC];
    bit corrupt[NC], p1[NC], p2[NC];

    function automatic logic [DW-1:0] lane_word(input int l);
        logic [DW-1:0] w;
        w = mode[l] == 0 ? rotl(rev(TP), phase[l]) : mode[l] == 1 ? cval[l] : DW'($urandom);
        return corrupt[l] ? ~w : w;
    endfunction

    task automatic refresh();
        for (int l = 0; l < NC; l++) data_in[l*DW +: DW] = lane_word(l);
    endtask

    // ISERDES: each bitslip rotates the lane's output 2 cycles later
    initial forever begin
        @(posedge clk);
        #1;
        for (int l = 0; l < NC; l++)
            if (reset) begin
                p1[l] = 0;
                p2[l] = 0;
            end else begin
                if (p2[l]) phase[l] = (phase[l] + 1) % DW;
                p2[l] = p1[l];
                p1[l] = bitslip[l];
            end
        refresh();
    end

    int pulses[NC], low[NC], mrun[NC], xrun[NC];
    bit dv = 0, prev_retrain = 0;
    logic [NC-1:0] prev_locked = '0, prev_err = '0;
    logic [NC*DW-1:0] prev_din;

    initial for (int l = 0; l < NC; l++) pulses[l] = 0;

    always @(negedge clk) begin
        if (reset) begin
            dv = 0;
            for (int l = 0; l < NC; l++) begin
                low[l] = 100;
                mrun[l] = 0;
                xrun[l] = 0;
            end
            prev_locked = '0;
            prev_err = '0;
            prev_retrain = 0;
        end else begin
            if (dv) check("data_out", data_out, rev_bus(prev_din));
            check("all_locked", all_locked, &locked);
            for (int l = 0; l < NC; l++) begin
                if (bitslip[l]) begin
                    pulses[l]++;
                    check_range("slip_gap", low[l], SET + 1, 1000);
                    low[l] = 0;
                end else if (low[l] < 1000) low[l]++;
                check_range("slip_cnt_max", slip_cnt[l*SW +: SW], 0, DW);
                check("lock_err_excl", locked[l] & align_err[l], 0);
                if (locked[l] && !prev_locked[l]) check_range("lock_run", mrun[l], MC, 1000000);
                if (!locked[l] && prev_locked[l] && !prev_retrain)
                    check_range("loss_run", xrun[l], LC, 1000000);
                if (align_err[l] && !prev_err[l]) check("err_slips", slip_cnt[l*SW +: SW], DW);
                if (data_out[l*DW +: DW] == TP) begin
                    mrun[l]++;
                    xrun[l] = 0;
                end else begin
                    xrun[l]++;
                    mrun[l] = 0;
                end
            end
            prev_locked = locked;
            prev_err = align_err;
            prev_retrain = retrain;
            prev_din = data_in;
            dv = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setup_rot(input int l, input int o);
        mode[l] = 0;
        phase[l] = (DW - o) % DW;
        corrupt[l] = 0;
    endtask

    task automatic align_round(input int a, input int b, input int c, input int d);
        int o[NC], base[NC], lock_at[NC];
        int all_at, maxl;
        o = '{a, b, c, d};
        reset = 1;
        train_en = 0;
        retrain = 0;
        for (int l = 0; l < NC; l++) setup_rot(l, o[l]);
        refresh();
        repeat (3) tick();
        reset = 0;
        train_en = 1;
        all_at = 0;
        for (int l = 0; l < NC; l++) begin
            base[l] = pulses[l];
            lock_at[l] = 0;
        end
        for (int n = 1; n <= 200 && all_at == 0; n++) begin
            tick();
            for (int l = 0; l < NC; l++) if (locked[l] && lock_at[l] == 0) lock_at[l] = n;
            if (all_locked) all_at = n;
        end
        maxl = 0;
        for (int l = 0; l < NC; l++) begin
            check_range("lock_time", lock_at[l], MC + 1 + (SET + 2) * o[l], MC + 2 + (SET + 2) * o[l]);
            check("pulses", pulses[l] - base[l], o[l]);
            check("slip_cnt", slip_cnt[l*SW +: SW], o[l]);
            if (lock_at[l] > maxl) maxl = lock_at[l];
        end
        check("all_locked_time", all_at, maxl);
    endtask

    task automatic loss_test(input int l);
        bit held;
        int n, base;
        held = 1;
        corrupt[l] = 1;
        refresh();
        repeat (3) begin
            tick();
            if (!locked[l]) held = 0;
        end
        corrupt[l] = 0;
        refresh();
        repeat (10) begin
            tick();
            if (!locked[l]) held = 0;
        end
        check("hold_lock", held, 1);
        corrupt[l] = 1;
        refresh();
        repeat (4) tick();
        corrupt[l] = 0;
        refresh();
        for (n = 0; n < 6 && locked[l]; n++) tick();
        check("loss_drop", locked[l], 0);
        check("loss_slip_cnt", slip_cnt[l*SW +: SW], 0);
        base = pulses[l];
        for (n = 0; n < 40 && !locked[l]; n++) tick();
        check("relock_time", n, MC);
        check("relock_pulses", pulses[l] - base, 0);
    endtask

    task automatic retrain_test();
        check("pre_retrain", all_locked, 1);
        retrain = 1;
        tick();
        retrain = 0;
        check("retrain_locked", locked, 0);
        check("retrain_all", all_locked, 0);
        for (int n = 0; n < 30 && !all_locked; n++) tick();
        check("retrain_relock", all_locked, 1);
    endtask

    task automatic fail_test();
        int base, err_at;
        reset = 1;
        train_en = 0;
        for (int l = 0; l < NC; l++) corrupt[l] = 0;
        setup_rot(0, $urandom_range(0, DW - 1));
        mode[1] = 2;
        mode[2] = 1;
        cval[2] = 10'h155;
        setup_rot(3, $urandom_range(0, DW - 1));
        refresh();
        repeat (2) tick();
        reset = 0;
        train_en = 1;
        base = pulses[2];
        err_at = 0;
        for (int n = 1; n <= 100 && err_at == 0; n++) begin
            tick();
            if (align_err[2]) err_at = n;
        end
        check_range("err_time", err_at, 2 + (SET + 2) * DW, 3 + (SET + 2) * DW);
        check("err_pulses", pulses[2] - base, DW);
        check("err_locked", locked[2], 0);
        check("err_slip_cnt", slip_cnt[2*SW +: SW], DW);
        train_en = 0;
        tick();
        check("err_clear", align_err[2], 0);
    endtask

    task automatic settle_reset_test();
        int n;
        repeat (8) tick();
        setup_rot(1, 3);
        refresh();
        retrain = 1;
        train_en = 1;
        tick();
        retrain = 0;
        for (n = 0; n < 10 && !bitslip[1]; n++) tick();
        check("slip_seen", bitslip[1], 1);
        repeat (2) tick();
        check("settle_cnt", slip_cnt[SW +: SW], 1);
        #1 reset = 1;
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_bitslip", bitslip, 0);
        check("rst_locked", locked, 0);
        check("rst_align_err", align_err, 0);
        check("rst_slip_cnt", slip_cnt, 0);
        check("rst_all_locked", all_locked, 0);
    endtask

    task automatic literal_test();
        logic [NC*DW-1:0] d;
        repeat (2) tick();
        train_en = 0;
        reset = 0;
        mode[0] = 1;
        cval[0] = 10'h001;
        corrupt[0] = 0;
        refresh();
        tick();
        d = data_out;
        check("rev_literal", d[DW-1:0], 10'h200);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < NC; l++) begin
            mode[l] = 0;
            phase[l] = 0;
            cval[l] = '0;
            corrupt[l] = 0;
        end
        align_round(0, 3, $urandom_range(0, DW - 1), $urandom_range(1, DW - 1));
        loss_test(3);
        retrain_test();
        repeat (2) align_round($urandom_range(0, DW - 1), $urandom_range(0, DW - 1),
                               $urandom_range(0, DW - 1), $urandom_range(0, DW - 1));
        fail_test();
        settle_reset_test();
        literal_test();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
